// File: rtl/i2c_calc_target.sv
// I2C target front end for the calculator: decodes controller writes into the
// operand/operation registers and returns a result snapshot on reads.
module i2c_calc_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [1:0]  operation,
    output logic        go,
    input  logic [63:0] result_i
);
    localparam int unsigned PTR_W  = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Synchroniser and edge-detect flops; idle bus level is high.
    logic scl_meta_q, scl_sync_q, scl_dly_q;
    logic sda_meta_q, sda_sync_q, sda_dly_q;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   sh_q, sh_d;
    logic [BYTE_W-1:0]   tx_q, tx_d;
    logic                rw_q, rw_d;
    logic                ack_q, ack_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [63:0]         snap_q, snap_d;
    logic [31:0]         operand_a_q, operand_a_d;
    logic [31:0]         operand_b_q, operand_b_d;
    logic [1:0]          operation_q, operation_d;
    logic                go_arm_q, go_arm_d;
    logic                go_q, go_d;
    logic                sda_oe_q, sda_oe_d;

    logic                scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [BYTE_W-1:0]   wbyte_c, rd_byte_c;
    logic [PTR_W-1:0]    rd_ptr_c;

    always_comb begin
        scl_rise_c = scl_sync_q & ~scl_dly_q;
        scl_fall_c = ~scl_sync_q & scl_dly_q;
        start_c    = scl_sync_q & scl_dly_q & sda_dly_q & ~sda_sync_q;
        stop_c     = scl_sync_q & scl_dly_q & ~sda_dly_q & sda_sync_q;
        wbyte_c    = {sh_q[6:0], sda_sync_q};
    end

    // Read mux: current pointer on RDATA entry, next pointer after a controller ACK.
    always_comb begin
        rd_ptr_c  = (state_q == RDATA_ACK) ? ptr_q + 5'd1 : ptr_q;
        rd_byte_c = 8'h00;
        case (rd_ptr_c[4:3])
            2'b00: begin
                if (rd_ptr_c[2]) rd_byte_c = operand_b_q[{rd_ptr_c[1:0], 3'b000} +: 8];
                else             rd_byte_c = operand_a_q[{rd_ptr_c[1:0], 3'b000} +: 8];
            end
            2'b01: begin
                if (rd_ptr_c == 5'h08) rd_byte_c = {6'b000000, operation_q};
            end
            2'b10:   rd_byte_c = snap_q[{rd_ptr_c[2:0], 3'b000} +: 8];
            default: rd_byte_c = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        ack_d       = ack_q;
        ptr_d       = ptr_q;
        snap_d      = snap_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        operation_d = operation_q;
        sda_oe_d    = sda_oe_q;
        go_arm_d    = 1'b0;
        go_d        = go_arm_q;

        if (start_c) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise_c && cnt_q < 4'd8) begin
                        sh_d  = wbyte_c;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7 && state_q == PTR) ptr_d = wbyte_c[4:0];
                        // Writes commit on the 8th sample; partial bytes never land.
                        if (cnt_q == 4'd7 && state_q == WDATA) begin
                            if (ptr_q < 5'd4) begin
                                operand_a_d[{ptr_q[1:0], 3'b000} +: 8] = wbyte_c;
                            end else if (ptr_q < 5'd8) begin
                                operand_b_d[{ptr_q[1:0], 3'b000} +: 8] = wbyte_c;
                            end else if (ptr_q == 5'd8) begin
                                operation_d = wbyte_c[1:0];
                                go_arm_d    = 1'b1;
                            end
                            ptr_d = ptr_q + 5'd1;
                        end
                    end else if (scl_fall_c && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (state_q != ADDR) begin
                            state_d  = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                            sda_oe_d = 1'b1;
                        end else if (sh_q[7:1] == TARGET_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            rw_d     = sh_q[0];
                            if (sh_q[0]) snap_d = result_i;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            state_d  = RDATA;
                            tx_d     = rd_byte_c;
                            sda_oe_d = ~rd_byte_c[7];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_c) begin
                        state_d  = WDATA;
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise_c && cnt_q < 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall_c) begin
                        if (cnt_q == 4'd8) begin
                            state_d  = RDATA_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[3'(4'd7 - cnt_q)];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_c) begin
                        ack_d = sda_sync_q;
                    end else if (scl_fall_c) begin
                        cnt_d = '0;
                        if (!ack_q) begin
                            state_d  = RDATA;
                            ptr_d    = ptr_q + 5'd1;
                            tx_d     = rd_byte_c;
                            sda_oe_d = ~rd_byte_c[7];
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_q  <= 1'b1;
            scl_sync_q  <= 1'b1;
            scl_dly_q   <= 1'b1;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
            sda_dly_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b1;
            ptr_q       <= '0;
            snap_q      <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            operation_q <= '0;
            go_arm_q    <= 1'b0;
            go_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            scl_meta_q  <= scl_i;
            scl_sync_q  <= scl_meta_q;
            scl_dly_q   <= scl_sync_q;
            sda_meta_q  <= sda_i;
            sda_sync_q  <= sda_meta_q;
            sda_dly_q   <= sda_sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            ptr_q       <= ptr_d;
            snap_q      <= snap_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            operation_q <= operation_d;
            go_arm_q    <= go_arm_d;
            go_q        <= go_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign operation = operation_q;
    assign go        = go_q;

endmodule

// File: tb/tb_i2c_calc_target.sv
// Bench for i2c_calc_target: bit-banged I2C controller plus a register-map
// reference model (byte array, pointer, snapshot) kept in the bench.
`timescale 1ns/1ps
module tb_i2c_calc_target;
    localparam int unsigned Q = 4;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] operand_a, operand_b;
    logic [1:0]  operation;
    logic        go;
    logic [63:0] result_i = '0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_calc_target #(.TARGET_ADDR(7'h42)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operation (operation),
        .go        (go),
        .result_i  (result_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Bus monitors
    int   go_rise = 0, go_hi = 0, oe_cycles = 0, oe_viol = 0;
    logic go_prev = 1'b0, oe_prev = 1'b0;
    always @(negedge clk) begin
        go_prev <= go;
        oe_prev <= sda_oe;
        if (go) go_hi <= go_hi + 1;
        if (go && !go_prev) go_rise <= go_rise + 1;
        if (sda_oe) oe_cycles <= oe_cycles + 1;
        if (rst_n && scl && (sda_oe !== oe_prev)) oe_viol <= oe_viol + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model
    logic [7:0]  m_regs [0:8];
    int          m_ptr = 0;
    int          m_go  = 0;
    logic [63:0] m_snap = '0;
    logic [7:0]  wbuf [0:15];
    logic [7:0]  rbuf [0:15];

    task automatic m_reset();
        for (int i = 0; i <= 8; i++) m_regs[i] = 8'h00;
        m_ptr  = 0;
        m_snap = '0;
    endtask

    task automatic m_write(input logic [7:0] b);
        if (m_ptr < 8) m_regs[m_ptr] = b;
        else if (m_ptr == 8) begin
            m_regs[8] = {6'b000000, b[1:0]};
            m_go++;
        end
        m_ptr = (m_ptr + 1) % 32;
    endtask

    function automatic logic [7:0] m_read(input int p);
        if (p <= 8) return m_regs[p];
        if (p >= 16 && p <= 23) return m_snap[8*(p-16) +: 8];
        return 8'h00;
    endfunction

    function automatic logic [31:0] m_opa();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [31:0] m_opb();
        return {m_regs[7], m_regs[6], m_regs[5], m_regs[4]};
    endfunction

    // Bit-level controller
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wclk(Q);
        scl   = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wclk(Q);
        scl   = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(2*Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wclk(Q);
        scl   = 1'b1; wclk(2*Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl   = 1'b1; wclk(Q);
        b     = sda_line; wclk(Q);
        scl   = 1'b0; wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(nack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic write_txn(input logic [4:0] p, input int n, output int nacks);
        logic nk;
        nacks = 0;
        bus_start();
        send_byte(8'h84, nk); nacks += (nk ? 1 : 0);
        send_byte({3'b000, p}, nk); nacks += (nk ? 1 : 0);
        m_ptr = int'(p);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], nk); nacks += (nk ? 1 : 0);
            m_write(wbuf[i]);
        end
        bus_stop();
    endtask

    task automatic read_txn(input bit set_ptr, input logic [4:0] p, input int n,
                            input int chg_at, input logic [63:0] chg_val, output int nacks);
        logic nk;
        nacks = 0;
        if (set_ptr) begin
            bus_start();
            send_byte(8'h84, nk); nacks += (nk ? 1 : 0);
            send_byte({3'b000, p}, nk); nacks += (nk ? 1 : 0);
            m_ptr = int'(p);
        end
        bus_start();
        m_snap = result_i;
        send_byte(8'h85, nk); nacks += (nk ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, rbuf[i]);
            if (i == chg_at) result_i = chg_val;
        end
        bus_stop();
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; result_i = '0;
        m_reset();
        wclk(4);
        rst_n = 1'b1;
        wclk(4);
        n_tests++; if (operand_a !== 32'h0) begin n_fail++; $display("FAIL reset_operand_a got %h want 0", operand_a); end
        n_tests++; if (operand_b !== 32'h0) begin n_fail++; $display("FAIL reset_operand_b got %h want 0", operand_b); end
        n_tests++; if (operation !== 2'h0)  begin n_fail++; $display("FAIL reset_operation got %h want 0", operation); end
        n_tests++; if (go !== 1'b0)         begin n_fail++; $display("FAIL reset_go got %b want 0", go); end
        n_tests++; if (sda_oe !== 1'b0)     begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    endtask

    task automatic test_write_operands();
        int nacks, gb, hb;
        logic [7:0] d [0:8] = '{8'h1C, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) wbuf[i] = d[i];
        gb = go_rise; hb = go_hi;
        write_txn(5'h00, 9, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL wr_acks nacks %0d want 0", nacks); end
        n_tests++; if (operand_a !== 32'd28) begin n_fail++; $display("FAIL wr_operand_a got %0d want 28", operand_a); end
        n_tests++; if (operand_b !== 32'd4)  begin n_fail++; $display("FAIL wr_operand_b got %0d want 4", operand_b); end
        n_tests++; if (operation !== 2'd0)   begin n_fail++; $display("FAIL wr_operation got %0d want 0", operation); end
        n_tests++; if (go_rise - gb !== 1)   begin n_fail++; $display("FAIL wr_go_pulses got %0d want 1", go_rise - gb); end
        n_tests++; if (go_hi - hb !== 1)     begin n_fail++; $display("FAIL wr_go_width got %0d want 1", go_hi - hb); end
    endtask

    task automatic test_read_result();
        int nacks;
        logic [7:0] exp;
        result_i = 64'h0123_4567_89AB_CDEF;
        read_txn(1'b1, 5'h10, 8, 3, 64'hDEAD_BEEF_FACE_F00D, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rd_acks nacks %0d want 0", nacks); end
        for (int i = 0; i < 8; i++) begin
            exp = m_read(m_ptr);
            n_tests++;
            if (rbuf[i] !== exp) begin n_fail++; $display("FAIL rd_byte%0d got %h want %h", i, rbuf[i], exp); end
            if (i < 7) m_ptr = (m_ptr + 1) % 32;
        end
    endtask

    task automatic test_wrong_addr();
        logic nk0, nk1;
        int ob, gb;
        ob = oe_cycles; gb = go_rise;
        bus_start();
        send_byte(8'h86, nk0);
        send_byte(8'h00, nk1);
        send_byte(8'h33, nk1);
        bus_stop();
        n_tests++; if (nk0 !== 1'b1) begin n_fail++; $display("FAIL wa_nack got %b want 1", nk0); end
        n_tests++; if (oe_cycles - ob !== 0) begin n_fail++; $display("FAIL wa_sda_oe cycles %0d want 0", oe_cycles - ob); end
        n_tests++; if (operand_a !== m_opa()) begin n_fail++; $display("FAIL wa_operand_a got %h want %h", operand_a, m_opa()); end
        n_tests++; if (operand_b !== m_opb()) begin n_fail++; $display("FAIL wa_operand_b got %h want %h", operand_b, m_opb()); end
        n_tests++; if (go_rise - gb !== 0) begin n_fail++; $display("FAIL wa_go got %0d pulses want 0", go_rise - gb); end
    endtask

    task automatic test_ptr_wrap();
        int nacks;
        logic [7:0] exp;
        read_txn(1'b1, 5'h1E, 3, 99, '0, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL wrap_acks nacks %0d want 0", nacks); end
        for (int i = 0; i < 3; i++) begin
            exp = m_read(m_ptr);
            n_tests++;
            if (rbuf[i] !== exp) begin n_fail++; $display("FAIL wrap_byte%0d got %h want %h", i, rbuf[i], exp); end
            if (i < 2) m_ptr = (m_ptr + 1) % 32;
        end
    endtask

    task automatic test_abort();
        logic nk;
        int nacks, gb;
        gb = go_rise;
        bus_start();
        send_byte(8'h84, nk);
        send_byte(8'h04, nk);
        m_ptr = 4;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        n_tests++; if (operand_b !== m_opb()) begin n_fail++; $display("FAIL abort_operand_b got %h want %h", operand_b, m_opb()); end
        n_tests++; if (go_rise - gb !== 0) begin n_fail++; $display("FAIL abort_go got %0d pulses want 0", go_rise - gb); end
        wbuf[0] = 8'h55;
        write_txn(5'h04, 1, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL abort_next_acks nacks %0d want 0", nacks); end
        n_tests++; if (operand_b !== m_opb()) begin n_fail++; $display("FAIL abort_next_operand_b got %h want %h", operand_b, m_opb()); end
    endtask

    task automatic test_random();
        int nacks, gb, mg, n;
        logic [4:0] p;
        bit set_ptr;
        logic [7:0] exp;
        for (int it = 0; it < 10; it++) begin
            p = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            gb = go_rise; mg = m_go;
            write_txn(p, n, nacks);
            n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_wr_acks nacks %0d want 0", it, nacks); end
            n_tests++; if (operand_a !== m_opa()) begin n_fail++; $display("FAIL rnd%0d_operand_a got %h want %h", it, operand_a, m_opa()); end
            n_tests++; if (operand_b !== m_opb()) begin n_fail++; $display("FAIL rnd%0d_operand_b got %h want %h", it, operand_b, m_opb()); end
            n_tests++; if (operation !== m_regs[8][1:0]) begin n_fail++; $display("FAIL rnd%0d_operation got %h want %h", it, operation, m_regs[8][1:0]); end
            n_tests++; if (go_rise - gb !== m_go - mg) begin n_fail++; $display("FAIL rnd%0d_go got %0d want %0d", it, go_rise - gb, m_go - mg); end

            result_i = {$urandom, $urandom};
            set_ptr  = ($urandom_range(0, 2) != 0);
            p = 5'($urandom_range(0, 31));
            n = int'($urandom_range(1, 5));
            read_txn(set_ptr, p, n, 99, '0, nacks);
            n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rnd%0d_rd_acks nacks %0d want 0", it, nacks); end
            for (int i = 0; i < n; i++) begin
                exp = m_read(m_ptr);
                n_tests++;
                if (rbuf[i] !== exp) begin n_fail++; $display("FAIL rnd%0d_rd_byte%0d ptr %0d got %h want %h", it, i, m_ptr, rbuf[i], exp); end
                if (i < n - 1) m_ptr = (m_ptr + 1) % 32;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic nk;
        int nacks;
        result_i = 64'hFFFF_FFFF_FFFF_FF00;
        bus_start();
        send_byte(8'h84, nk);
        send_byte(8'h10, nk);
        bus_start();
        send_byte(8'h85, nk);
        for (int i = 0; i < 12 && sda_oe !== 1'b1; i++) wclk(1);
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_rd_driving sda_oe %b want 1 (timeout)", sda_oe); end
        rst_n = 1'b0;
        #1;
        m_reset();
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_rd_sda_oe got %b want 0", sda_oe); end
        n_tests++; if (operand_a !== 32'h0 || operand_b !== 32'h0 || operation !== 2'h0 || go !== 1'b0) begin
            n_fail++; $display("FAIL rst_rd_outputs got a=%h b=%h op=%h go=%b want all 0", operand_a, operand_b, operation, go);
        end
        wclk(3);
        rst_n = 1'b1;
        wclk(3);
        bus_stop();
        wbuf[0] = 8'hA5;
        write_txn(5'h00, 1, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rst_rd_next_acks nacks %0d want 0", nacks); end
        n_tests++; if (operand_a !== m_opa()) begin n_fail++; $display("FAIL rst_rd_next_operand_a got %h want %h", operand_a, m_opa()); end
    endtask

    task automatic test_oe_timing();
        n_tests++;
        if (oe_viol !== 0) begin n_fail++; $display("FAIL oe_timing changes while SCL high %0d want 0", oe_viol); end
    endtask

    initial begin
        test_reset();
        test_write_operands();
        test_read_result();
        test_wrong_addr();
        test_ptr_wrap();
        test_abort();
        test_random();
        test_reset_mid_read();
        test_oe_timing();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_calc_target.md
# i2c_calc_target

I2C target (peripheral) front end for the calculator. Decodes an external controller's bus transactions into the calculator's operand and operation registers, issues a one-cycle start pulse, and returns the 64-bit result over the bus on read. Sits between the chip's I2C pins (open-drain via `uio`) and the calculator core, replacing the fixed operand values.

## Interface

Parameters:
- `TARGET_ADDR`, default `7'h42`: 7-bit I2C address this block answers to.

Ports:
- `clk`  in  1  system clock; must run at least 10× the SCL frequency.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `scl_i`  in  1  raw SCL pin (asynchronous).
- `sda_i`  in  1  raw SDA pin (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. The pin value is always 0.
- `operand_a`  out  32  first operand, register 0x00–0x03, little-endian.
- `operand_b`  out  32  second operand, register 0x04–0x07, little-endian.
- `operation`  out  2  operation select, register 0x08 bits [1:0].
- `go`  out  1  one-`clk` pulse after register 0x08 is written.
- `result_i`  in  64  calculator result; read back at 0x10–0x17, little-endian.

## Operation

- **Synchronisation:**
  - SCL and SDA each pass through a 2-flop synchroniser.
  - All decoding uses the synchronised values and their 1-cycle-delayed copies.
- **Bus conditions:**
  - START or repeated START: SDA falls while SCL is high. From any state, go to ADDR and clear the bit counter.
  - STOP: SDA rises while SCL is high. From any state, go to IDLE and set `sda_oe` = 0.
- **Bit timing:**
  - Data is sampled on the SCL rising edge.
  - `sda_oe` changes only on the SCL falling edge.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
    - Bits [7:1] == `TARGET_ADDR`: go to ADDR_ACK.
    - Otherwise: go to IGNORE; `sda_oe` stays 0.
  - ADDR_ACK: drive ACK for one SCL period.
    - R/W = 0: go to PTR.
    - R/W = 1: latch `result_i` into a 64-bit snapshot register at ADDR_ACK entry, then go to RDATA.
  - PTR: receive 1 byte. Bits [4:0] load the 5-bit pointer; bits [7:5] are ignored. Go to PTR_ACK (ACK), then WDATA.
  - WDATA: receive 1 byte, write it at the pointer, go to WDATA_ACK (ACK), pointer += 1, return to WDATA.
  - RDATA: drive 8 bits, MSB first, of the byte at the pointer. Go to RDATA_ACK: release SDA and sample the controller's ACK.
    - ACK (0): pointer += 1, load the next byte, return to RDATA.
    - NACK (1): go to IGNORE.
  - IGNORE: `sda_oe` = 0 until the next START or STOP.
- **Register map:**
  - 0x00–0x08: read/write.
  - 0x10–0x17: read-only result snapshot.
  - Writes to read-only or unmapped addresses are ACKed and discarded.
  - Reads of unmapped addresses return 0x00.
  - Reading 0x00–0x08 returns the current register value.
- **Pointer:** 5 bits, wraps from 0x1F to 0x00. The pointer persists across transactions, so a read without a preceding PTR write continues from the last pointer.
- **`go`:** pulses high for exactly one `clk`, in the cycle after the write to 0x08 commits (at the 8th-bit SCL rise). Bytes written to 0x00–0x07 do not pulse `go`.
- **Commit rules:**
  - Operand byte writes update the outputs immediately when the 8th bit is sampled.
  - A transaction aborted by STOP or START mid-byte discards the partial byte.

## Timing

- **Reset values (async):**
  - All outputs are 0: `operand_a`, `operand_b`, `operation`, `go`, `sda_oe`.
  - Pointer 0, snapshot 0, state IDLE.
- **Latency:** about 3 `clk` from a pin edge to detection (2 sync + 1 edge detect).
- **ACK window:**
  - `sda_oe` asserts at the SCL fall after the 8th bit.
  - `sda_oe` deasserts (or the next read bit is driven) at the following SCL fall.
- **Register updates:**
  - Operand and operation outputs change 1 `clk` after the detection of the 8th SCL rise.
  - `go` follows in the next cycle.
- **Snapshot:** taken 1 `clk` after address match with R/W = 1. Later changes of `result_i` are invisible until the next read address phase.
- **Reset mid-transaction:** immediately returns to the reset state and releases SDA. Any bytes already committed are lost (they reset to 0).

## Test plan

- **Write operands:** addr 0x84, ptr 0x00, then data 1C 00 00 00 04 00 00 00 00, STOP.
  - Every byte is ACKed.
  - `operand_a` = 28, `operand_b` = 4, `operation` = 0.
  - Exactly one `go` pulse.
- **Read result:** `result_i` = 64'h0123_4567_89AB_CDEF. Write addr 0x84, ptr 0x10, Sr, addr 0x85, then read 8 bytes (ACK 7, NACK the last).
  - Bytes returned: EF CD AB 89 67 45 23 01.
  - Changing `result_i` mid-read does not alter the returned bytes.
- **Wrong address:** addr 0x86.
  - No ACK; `sda_oe` stays 0 for the whole transaction.
  - All outputs unchanged; `go` = 0.
- **Pointer wrap / unmapped:** ptr 0x1E, read 3 bytes.
  - Returns 00 00 1C (0x1E, 0x1F, then 0x00 holding 0x1C from the first test).
- **Abort:** STOP after 4 bits of a data byte to 0x04.
  - `operand_b` unchanged; no `go`; the next transaction works normally.
- **Async reset mid-read:** assert `rst_n` = 0 while `sda_oe` = 1.
  - `sda_oe` = 0 and all outputs are 0 immediately.
  - After release, a new write transaction is ACKed.
